icache_dm: RTL and testbench

Direct-mapped, single-word-block instruction cache that sits directly downstream of the pipelined datapath's fetch stage. It serves the datapath's instruction requests (`imemREN`, `imemaddr`) and returns `ihit` and `imemload`. On a miss it runs a blocking fill from the memory controller through a request/wait handshake. While `ihit` is low the PC is held and the IF/ID latch sees a stall.

---
 rtl/icache_dm.sv | 73 +++++++
 tb/tb_icache_dm.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped single-word-block instruction cache with blocking fill
module icache_dm #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);
    localparam int IDX = $clog2(SETS);
    localparam int TAG = 30 - IDX;
    typedef enum logic {IDLE, FETCH} state_t;
    state_t state, next_state;
    logic [SETS-1:0] valid;
    logic [TAG-1:0] tags [SETS];
    logic [31:0] data [SETS];
    logic [29:0] miss_addr;
    logic [IDX-1:0] idx, miss_idx;
    logic [TAG-1:0] tag, miss_tag;
    logic hit, fill, unused_ok;
    assign idx = imemaddr[IDX+1:2];
    assign tag = imemaddr[31:IDX+2];
    assign miss_idx = miss_addr[IDX-1:0];
    assign miss_tag = miss_addr[29:IDX];
    assign hit = imemREN && valid[idx] && tags[idx] == tag;
    assign unused_ok = ^imemaddr[1:0];
    always_comb begin
        next_state = state;
        ihit = 1'b0;
        imemload = '0;
        iREN = 1'b0;
        iaddr = '0;
        fill = 1'b0;
        if (!RST) begin
            if (state == IDLE) begin
                ihit = hit;
                imemload = hit ? data[idx] : '0;
                next_state = (imemREN && !hit) ? FETCH : IDLE;
            end else begin
                iREN = 1'b1;
                iaddr = {miss_addr, 2'b00};
                fill = !iwait && !flush;
                next_state = (!iwait || flush) ? IDLE : FETCH;
            end
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            valid <= '0;
            miss_addr <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && imemREN && !hit) miss_addr <= imemaddr[31:2];
            if (flush) valid <= '0;
            else if (fill) valid[miss_idx] <= 1'b1;
        end
    end
    // Tag and data carry no reset; valid alone qualifies them.
    always_ff @(posedge CLK) begin
        if (fill) begin
            data[miss_idx] <= iload;
            tags[miss_idx] <= miss_tag;
        end
    end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: randomized and directed checks of icache_dm against a behavioural cache model
module tb_icache_dm;
    localparam int SETS = 16;
    logic        CLK = 1'b0;
    logic        RST, imemREN, flush, iwait;
    logic [31:0] imemaddr, iload;
    logic        ihit, iREN;
    logic [31:0] imemload, iaddr;

    icache_dm #(.SETS(SETS)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .ihit(ihit), .imemload(imemload), .flush(flush),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_pass = 0;

    // Model: what the cache holds, and whether a fill is outstanding.
    bit          m_valid [SETS];
    int unsigned m_tag   [SETS];
    logic [31:0] m_data  [SETS];
    bit          busy;
    logic [31:0] pend;

    logic        obs_ihit, obs_iren;
    logic [31:0] obs_load, obs_iaddr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic step(input logic r, input logic ren, input logic [31:0] a,
                        input logic fl, input logic w, input logic [31:0] ld);
        int unsigned si, st;
        bit h;
        logic [31:0] e_load, e_iaddr;
        @(negedge CLK);
        RST = r; imemREN = ren; imemaddr = a; flush = fl; iwait = w; iload = ld;
        #1;
        si = (a / 4) % SETS;
        st = a / (4 * SETS);
        h = !r && !busy && ren && m_valid[si] && m_tag[si] == st;
        e_load = h ? m_data[si] : 32'h0;
        e_iaddr = (!r && busy) ? (pend / 4) * 4 : 32'h0;
        check("ihit", {31'b0, ihit}, {31'b0, h});
        check("imemload", imemload, e_load);
        check("iREN", {31'b0, iREN}, {31'b0, !r && busy});
        check("iaddr", iaddr, e_iaddr);
        obs_ihit = ihit; obs_iren = iREN; obs_load = imemload; obs_iaddr = iaddr;
        @(posedge CLK);
        if (r) begin
            foreach (m_valid[i]) m_valid[i] = 0;
            busy = 0;
            pend = 0;
        end else if (!busy) begin
            if (fl) foreach (m_valid[i]) m_valid[i] = 0;
            if (ren && !h) begin
                busy = 1;
                pend = a;
            end
        end else if (fl) begin
            foreach (m_valid[i]) m_valid[i] = 0;
            busy = 0;
        end else if (!w) begin
            si = (pend / 4) % SETS;
            m_valid[si] = 1;
            m_tag[si] = pend / (4 * SETS);
            m_data[si] = ld;
            busy = 0;
        end
    endtask

    task automatic access(input logic [31:0] a, input logic [31:0] d, output logic was_hit);
        step(0, 1, a, 0, 0, d);
        was_hit = obs_ihit;
        if (!was_hit) begin
            step(0, 1, a, 0, 0, d);
            step(0, 1, a, 0, 0, d);
        end
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic wh;
        int cnt, first;
        busy = 0; pend = 0;
        foreach (m_valid[i]) m_valid[i] = 0;
        do_reset();
        check("rst_ihit", {31'b0, obs_ihit}, 32'h0);
        check("rst_iREN", {31'b0, obs_iren}, 32'h0);
        step(0, 1, 32'h4, 0, 0, 32'h2001_0005);
        check("cold_c0_ihit", {31'b0, obs_ihit}, 32'h0);
        step(0, 1, 32'h4, 0, 0, 32'h2001_0005);
        check("cold_c1_iREN", {31'b0, obs_iren}, 32'h1);
        check("cold_c1_iaddr", obs_iaddr, 32'h4);
        step(0, 1, 32'h4, 0, 0, 32'h2001_0005);
        check("cold_c2_ihit", {31'b0, obs_ihit}, 32'h1);
        check("cold_c2_load", obs_load, 32'h2001_0005);
        cnt = 0; first = -1;
        for (int k = 0; k < 7; k++) begin
            step(0, 1, 32'h84, 0, k >= 1 && k <= 3, 32'hCAFE_0084);
            if (obs_iren) cnt++;
            if (obs_ihit && first < 0) first = k;
        end
        check("wait_iren_cycles", cnt, 4);
        check("wait_hit_latency", first, 5);
        do_reset();
        access(32'h00, 32'hAAAA_0000, wh);
        access(32'h40, 32'hBBBB_0040, wh);
        check("evict_b_miss", {31'b0, wh}, 32'h0);
        access(32'h00, 32'hAAAA_0000, wh);
        check("evict_a_remiss", {31'b0, wh}, 32'h0);
        access(32'h00, 32'hAAAA_0000, wh);
        check("evict_a_hit", {31'b0, wh}, 32'h1);
        access(32'h44, 32'h4444_4444, wh);
        check("cold_idx1_miss", {31'b0, wh}, 32'h0);
        access(32'h08, 32'h0808_0808, wh);
        step(0, 0, 32'h08, 1, 0, 0);
        access(32'h08, 32'h0808_0808, wh);
        check("flush_idle_miss", {31'b0, wh}, 32'h0);
        access(32'h08, 32'h0808_0808, wh);
        check("refill_hit", {31'b0, wh}, 32'h1);
        step(0, 1, 32'h0C, 0, 0, 32'h0C0C_0C0C);
        step(0, 1, 32'h0C, 1, 0, 32'h0C0C_0C0C);
        access(32'h0C, 32'h0C0C_0C0C, wh);
        check("flush_fill_miss", {31'b0, wh}, 32'h0);
        step(0, 1, 32'h30, 0, 1, 32'h3030_3030);
        step(0, 1, 32'h30, 0, 1, 32'h3030_3030);
        step(1, 1, 32'h30, 0, 1, 32'h3030_3030);
        check("rst_fetch_iREN", {31'b0, obs_iren}, 32'h0);
        access(32'h30, 32'h3030_3030, wh);
        check("rst_fetch_remiss", {31'b0, wh}, 32'h0);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step(0, 0, $urandom_range(0, 255), 0, $urandom_range(0, 1), $urandom);
            cnt += int'(obs_iren) + int'(obs_ihit);
        end
        check("idle_quiet", cnt, 0);
        do_reset();
        step(0, 1, 32'h10, 0, 1, 32'h1010_1010);
        step(0, 1, 32'h20, 0, 1, 32'h1010_1010);
        check("addr_change_iaddr", obs_iaddr, 32'h10);
        step(0, 0, 32'h20, 0, 0, 32'h1010_1010);
        access(32'h20, 32'h2020_2020, wh);
        check("addr_change_miss", {31'b0, wh}, 32'h0);
        access(32'h10, 32'h1010_1010, wh);
        check("addr_change_filled", {31'b0, wh}, 32'h1);
        for (int k = 0; k < 3000; k++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8,
                 {24'b0, $urandom_range(0, 63) * 4 + $urandom_range(0, 3)},
                 $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 3, $urandom);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
